// File: rtl/jtdd_mcu_pkg.sv
// Shared definitions for the Double Dragon sub-CPU controller: the
// arbitration state encoding and the control register offsets.
package jtdd_mcu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACC  = 2'd2,
    REL  = 2'd3
  } arb_state_t;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_NMI  = 2'd1;
  localparam logic [1:0] REG_IACK = 2'd2;
  localparam logic [1:0] REG_EACK = 2'd3;

endpackage

// File: rtl/jtdd_mcu_arb.sv
// Shared RAM arbiter: halts the MCU when the main CPU selects the shared
// RAM and stalls the CPU until the MCU confirms it is off the bus. A
// timeout forces the grant so a stuck MCU can never deadlock the CPU.
module jtdd_mcu_arb
  import jtdd_mcu_pkg::*;
#(
  parameter int TOUT = 1023,
  parameter int TW   = 10
) (
  input  logic clk,
  input  logic rstb,
  input  logic cen,
  input  logic com_cs,
  input  logic mcu_rstb,
  input  logic mcu_halted,
  output logic fsm_halt,
  output logic cpu_waitn,
  output logic tout_set
);

  localparam logic [TW-1:0] TOUT_W = TW'(TOUT);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [TW-1:0] cnt;
  logic [TW-1:0] cnt_nxt;
  logic [TW-1:0] cnt_inc;

  assign cnt_inc = cnt + 1'b1;

  // State and timeout counter only advance on CPU clock enable
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (cen) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state plus halt/wait outputs; IDLE asserts them as soon as com_cs shows up
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fsm_halt  = 1'b0;
    cpu_waitn = 1'b1;
    tout_set  = 1'b0;
    case (state)
      IDLE: begin
        if (com_cs) begin
          if (!mcu_rstb || mcu_halted) begin
            state_nxt = ACC;
          end else begin
            state_nxt = REQ;
            fsm_halt  = 1'b1;
            cpu_waitn = 1'b0;
            cnt_nxt   = '0;
          end
        end
      end
      REQ: begin
        fsm_halt  = 1'b1;
        cpu_waitn = 1'b0;
        cnt_nxt   = cnt_inc;
        if (!com_cs) begin
          state_nxt = REL;
        end else if (!mcu_rstb || mcu_halted) begin
          state_nxt = ACC;
        end else if (cnt_inc == TOUT_W) begin
          state_nxt = ACC;
          tout_set  = cen;
        end
      end
      ACC: begin
        fsm_halt = 1'b1;
        if (!com_cs) state_nxt = REL;
      end
      REL: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/jtdd_mcu_ctrl.sv
// Main-CPU side controller for the 6801 sub-CPU: control register file,
// MCU-to-main interrupt latch, timeout status and shared RAM arbitration.
module jtdd_mcu_ctrl
  import jtdd_mcu_pkg::*;
#(
  parameter int TOUT = 1023,
  parameter int TW   = 10
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       cen,
  input  logic [1:0] cpu_AB,
  input  logic       cpu_wrn,
  input  logic [7:0] cpu_dout,
  input  logic       io_cs,
  input  logic       com_cs,
  input  logic       mcu_irqmain,
  input  logic       mcu_halted,
  input  logic       mcu_ban,
  output logic       mcu_rstb,
  output logic       mcu_halt,
  output logic       mcu_nmi_set,
  output logic       cpu_waitn,
  output logic       main_irq,
  output logic [7:0] st_dout,
  output logic       tout_err
);

  logic wr;
  logic wr_last;
  logic wr_edge;
  logic halt_reg;
  logic irq_last;
  logic irq_set;
  logic fsm_halt;
  logic tout_set;
  logic dout_unused;

  assign wr          = io_cs & ~cpu_wrn;
  assign wr_edge     = cen & wr & ~wr_last;
  assign irq_set     = mcu_irqmain & ~irq_last;
  assign mcu_halt    = halt_reg | fsm_halt;
  assign st_dout     = {4'd0, tout_err, mcu_ban, mcu_halted, main_irq};
  assign dout_unused = ^cpu_dout[7:2];

  // Remember the write strobe so a long strobe performs a single write
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) wr_last <= 1'b0;
    else if (cen) wr_last <= wr;
  end

  // Control register and the one-clock NMI set pulse
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mcu_rstb    <= 1'b0;
      halt_reg    <= 1'b0;
      mcu_nmi_set <= 1'b0;
    end else begin
      mcu_nmi_set <= wr_edge && (cpu_AB == REG_NMI);
      if (wr_edge && (cpu_AB == REG_CTRL)) begin
        mcu_rstb <= cpu_dout[0];
        halt_reg <= cpu_dout[1];
      end
    end
  end

  // MCU request edge latch; a new request beats a simultaneous acknowledge
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      irq_last <= 1'b0;
      main_irq <= 1'b0;
    end else begin
      irq_last <= mcu_irqmain;
      if (irq_set) main_irq <= 1'b1;
      else if (wr_edge && (cpu_AB == REG_IACK)) main_irq <= 1'b0;
    end
  end

  // Sticky timeout flag, cleared by the CPU acknowledge register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) tout_err <= 1'b0;
    else if (tout_set) tout_err <= 1'b1;
    else if (wr_edge && (cpu_AB == REG_EACK)) tout_err <= 1'b0;
  end

  jtdd_mcu_arb #(
    .TOUT (TOUT),
    .TW   (TW)
  ) u_arb (
    .clk        (clk),
    .rstb       (rstb),
    .cen        (cen),
    .com_cs     (com_cs),
    .mcu_rstb   (mcu_rstb),
    .mcu_halted (mcu_halted),
    .fsm_halt   (fsm_halt),
    .cpu_waitn  (cpu_waitn),
    .tout_set   (tout_set)
  );

endmodule

// File: doc/jtdd_mcu_ctrl.md
Name: jtdd_mcu_ctrl

Overview:
Main-CPU-side controller for the Double Dragon 6801 sub-CPU. It drives the MCU control inputs: reset, halt, and NMI set. It collects the MCU's request line into a main-CPU interrupt. It also arbitrates main-CPU accesses to the shared RAM by halting the MCU and inserting CPU wait states until the MCU confirms it has halted. It sits between the main CPU address decoder and the MCU wrapper.

Parameters:
TOUT, 1023, maximum cen cycles to wait for mcu_halted before forcing release.
TW, 10, width of the timeout counter; must satisfy 2**TW > TOUT.

Ports:
clk  input  1  system clock
rstb  input  1  asynchronous active-low reset
cen  input  1  main CPU clock enable; all FSM and counter steps are qualified by it
cpu_AB  input  2  main CPU address LSBs selecting the control register
cpu_wrn  input  1  main CPU write strobe, active low
cpu_dout  input  8  main CPU write data
io_cs  input  1  control register select
com_cs  input  1  shared RAM select (main CPU side)
mcu_irqmain  input  1  request line from MCU port 6 bit 1
mcu_halted  input  1  MCU halted acknowledge
mcu_ban  input  1  MCU bus active (vma); status only
mcu_rstb  output  1  MCU reset, active low
mcu_halt  output  1  MCU halt request
mcu_nmi_set  output  1  one-clk pulse; sets the NMI flip-flop in the MCU
cpu_waitn  output  1  main CPU wait, low = stall
main_irq  output  1  pending interrupt to main CPU
st_dout  output  8  status read data
tout_err  output  1  sticky flag: a halt handshake timed out

Behaviour:
- Reset values: mcu_rstb=0, mcu_halt=0, mcu_nmi_set=0, cpu_waitn=1, main_irq=0, tout_err=0, FSM=IDLE, counter=0.
- Register writes: io_cs & ~cpu_wrn, sampled on the clk edge with cen=1. Only one write per access, edge-detected on the write strobe.
  - AB=0: bit0 -> mcu_rstb, bit1 -> halt_reg.
  - AB=1: any data -> mcu_nmi_set high for exactly 1 clk.
  - AB=2: any data -> clear main_irq.
  - AB=3: any data -> clear tout_err.
- st_dout is combinational: {4'd0, tout_err, mcu_ban, mcu_halted, main_irq}. It does not depend on AB.
- main_irq:
  - Set on a rising edge of mcu_irqmain, detected with a registered previous value sampled every clk.
  - Cleared by an AB=2 write.
  - A set and a clear in the same clk: set wins.
- mcu_halt = halt_reg | fsm_halt.
- Arbitration FSM states: IDLE, REQ, ACC, REL.
  - IDLE: on com_cs:
    - If mcu_rstb=0 or mcu_halted=1 already: go to ACC; cpu_waitn stays 1.
    - Otherwise: go to REQ. fsm_halt=1 and cpu_waitn=0 in the same clk as com_cs is first seen; counter=0.
  - REQ: counter increments on cen.
    - mcu_halted=1 -> ACC, cpu_waitn=1 next clk.
    - counter==TOUT -> ACC with tout_err=1 (forced release, prevents deadlock).
    - com_cs dropping in REQ -> REL.
  - ACC: fsm_halt held; cpu_waitn=1; stay while com_cs=1. com_cs=0 -> REL.
  - REL: fsm_halt=0; return to IDLE next clk. A new com_cs in REL is serviced from IDLE; no access is lost.
- Taking mcu_rstb low during REQ grants ACC on the next clk (MCU not on the bus).
- Latency: wait-free access when the MCU is already halted. Otherwise stall = halted latency + 1 clk.
- Asynchronous reset mid-handshake: all state returns to reset values immediately; cpu_waitn=1.

Decomposition:
- Package jtdd_mcu_pkg: FSM state encoding (IDLE=0, REQ=1, ACC=2, REL=3) and register offsets (CTRL=0, NMI=1, IACK=2, EACK=3).
- One natural sub-module: jtdd_mcu_arb, holding the FSM plus timeout counter.
- Register file and IRQ latch remain in the top module.

Test Plan:
- Reset then write AB=0 data 8'h01 -> mcu_rstb=1, mcu_halt=0. Write AB=1 -> mcu_nmi_set high exactly 1 clk.
- Pulse mcu_irqmain 0->1 -> main_irq=1, st_dout=8'h01. Write AB=2 -> main_irq=0. Edge coincident with ack -> main_irq stays 1.
- com_cs with mcu_halted=0; raise mcu_halted 5 cen later -> mcu_halt=1 immediately, cpu_waitn low for 6 clk, then 1. Drop com_cs -> mcu_halt=0 after REL.
- com_cs with mcu_halted never rising, TOUT=15 -> cpu_waitn returns to 1 after 16 cen, tout_err=1. Write AB=3 -> tout_err=0.
- halt_reg=1 with mcu_halted=1, then com_cs -> no wait states. Clear halt_reg -> mcu_halt stays 1 until com_cs drops.
- Assert rstb=0 during REQ -> cpu_waitn=1, mcu_halt=0, mcu_rstb=0 in the same clk; no spurious NMI after release.
